// File: rtl/controle_rolagem_pkg.sv
// Shared cell command codes and controller states for the display scroll register.
package pkg_rolagem;

    localparam logic [1:0] SEL_CARGA     = 2'b00;
    localparam logic [1:0] SEL_POSTERIOR = 2'b01;
    localparam logic [1:0] SEL_ANTERIOR  = 2'b10;
    localparam logic [1:0] SEL_MANTEM    = 2'b11;

    typedef enum logic {
        OCIOSO = 1'b0,
        CONTA  = 1'b1
    } estado_t;

endpackage

// File: rtl/controle_rolagem_if.sv
// Pattern-source / column-driver bus of the scroll controller.
// Optional step counter signals exist only when CONTADOR_PASSOS_EN is defined.
interface controle_rolagem_if #(
    parameter int LARGURA = 8
);
    logic               carregar;
    logic [LARGURA-1:0] entrada_paralela;
    logic               rolar;
    logic               direcao;
    logic               rotacao;
    logic [1:0]         sel;
    logic [LARGURA-1:0] saida;
    logic               passo;
    logic               ocupado;
`ifdef CONTADOR_PASSOS_EN
    logic [$clog2(LARGURA)-1:0] num_passos;
    logic                       volta_completa;

    modport master (
        output carregar, entrada_paralela, rolar, direcao, rotacao,
        input  sel, saida, passo, ocupado, num_passos, volta_completa
    );
    modport slave (
        input  carregar, entrada_paralela, rolar, direcao, rotacao,
        output sel, saida, passo, ocupado, num_passos, volta_completa
    );
`else
    modport master (
        output carregar, entrada_paralela, rolar, direcao, rotacao,
        input  sel, saida, passo, ocupado
    );
    modport slave (
        input  carregar, entrada_paralela, rolar, direcao, rotacao,
        output sel, saida, passo, ocupado
    );
`endif
endinterface

// File: rtl/controle_rolagem_celula_deslocamento.sv
// One bit of the universal shift register: a flop behind a 4:1 select on the command code.
module celula_deslocamento
    import pkg_rolagem::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] sel,
    input  logic       carga,
    input  logic       posterior,
    input  logic       anterior,
    output logic       q
);

    // NOTE: sequential state is written with <= so every cell samples its
    // neighbours' pre-edge values; blocking here would ripple a shift through.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= 1'b0;
        end else begin
            unique case (sel)
                SEL_CARGA:     q <= carga;
                SEL_POSTERIOR: q <= posterior;
                SEL_ANTERIOR:  q <= anterior;
                default:       q <= q;
            endcase
        end
    end

endmodule

// File: rtl/controle_rolagem.sv
// Sequenced scroll controller: issues cell commands to a LARGURA-bit register and
// scrolls it every DIV_PASSO cycles. Optional feature macro: CONTADOR_PASSOS_EN.
module controle_rolagem
    import pkg_rolagem::*;
#(
    parameter int LARGURA   = 8,
    parameter int DIV_PASSO = 4
) (
    input  logic              clk,
    input  logic              reset,
    controle_rolagem_if.slave barramento
);

    localparam int LC = (DIV_PASSO > 1) ? $clog2(DIV_PASSO) : 1;
    localparam logic [LC-1:0] ULTIMO = LC'(DIV_PASSO - 1);

    estado_t            estado, estado_prox;
    logic [LC-1:0]      cont, cont_prox;
    logic [1:0]         cmd;
    logic [1:0]         sel_q;
    logic               passo_prox, passo_q;
    logic [LARGURA-1:0] q;
    logic [LARGURA-1:0] viz_posterior, viz_anterior;
    logic               fim_msb, fim_lsb;

    // End cells see either the opposite end (rotate) or a constant zero.
    assign fim_msb       = barramento.rotacao ? q[0]         : 1'b0;
    assign fim_lsb       = barramento.rotacao ? q[LARGURA-1] : 1'b0;
    assign viz_posterior = {fim_msb, q[LARGURA-1:1]};
    assign viz_anterior  = {q[LARGURA-2:0], fim_lsb};

    // NOTE: every always_comb output gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        estado_prox = estado;
        cont_prox   = cont;
        cmd         = SEL_MANTEM;
        passo_prox  = 1'b0;
        if (barramento.carregar) begin
            cmd         = SEL_CARGA;
            cont_prox   = '0;
            estado_prox = barramento.rolar ? CONTA : OCIOSO;
        end else begin
            unique case (estado)
                OCIOSO: begin
                    cont_prox = '0;
                    if (barramento.rolar) estado_prox = CONTA;
                end
                CONTA: begin
                    if (!barramento.rolar) begin
                        estado_prox = OCIOSO;
                        cont_prox   = '0;
                    end else if (cont == ULTIMO) begin
                        cmd        = barramento.direcao ? SEL_ANTERIOR : SEL_POSTERIOR;
                        passo_prox = 1'b1;
                        cont_prox  = '0;
                    end else begin
                        cont_prox = cont + 1'b1;
                    end
                end
                default: estado_prox = OCIOSO;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado  <= OCIOSO;
            cont    <= '0;
            sel_q   <= SEL_MANTEM;
            passo_q <= 1'b0;
        end else begin
            estado  <= estado_prox;
            cont    <= cont_prox;
            sel_q   <= cmd;
            passo_q <= passo_prox;
        end
    end

    for (genvar i = 0; i < LARGURA; i++) begin : g_celula
        celula_deslocamento u_celula (
            .clk       (clk),
            .reset     (reset),
            .sel       (cmd),
            .carga     (barramento.entrada_paralela[i]),
            .posterior (viz_posterior[i]),
            .anterior  (viz_anterior[i]),
            .q         (q[i])
        );
    end

    assign barramento.saida   = q;
    assign barramento.sel     = sel_q;
    assign barramento.passo   = passo_q;
    assign barramento.ocupado = (estado == CONTA);

`ifdef CONTADOR_PASSOS_EN
    localparam int LN = $clog2(LARGURA);
    localparam logic [LN-1:0] ULTIMO_PASSO = LN'(LARGURA - 1);

    logic [LN-1:0] num_q;
    logic          volta_q;

    // The wrap pulse is registered with the shift so it lines up with passo.
    always_ff @(posedge clk) begin
        if (reset || barramento.carregar) begin
            num_q   <= '0;
            volta_q <= 1'b0;
        end else if (passo_prox) begin
            if (num_q == ULTIMO_PASSO) begin
                num_q   <= '0;
                volta_q <= 1'b1;
            end else begin
                num_q   <= num_q + 1'b1;
                volta_q <= 1'b0;
            end
        end else begin
            volta_q <= 1'b0;
        end
    end

    assign barramento.num_passos     = num_q;
    assign barramento.volta_completa = volta_q;
`endif

endmodule

// File: tb/tb_controle_rolagem.sv
// Scoreboard bench for controle_rolagem (LARGURA=8, DIV_PASSO=4).
// Covers the CONTADOR_PASSOS_EN outputs when that macro is defined.
module tb_controle_rolagem;

    localparam int LARGURA   = 8;
    localparam int DIV_PASSO = 4;

    typedef struct packed {
        logic [7:0] saida;
        logic [1:0] sel;
        logic       passo;
        logic       ocupado;
    } amostra_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    amostra_t fila[$];

    controle_rolagem_if #(.LARGURA(LARGURA)) bus ();

    controle_rolagem #(.LARGURA(LARGURA), .DIV_PASSO(DIV_PASSO)) dut (
        .clk        (clk),
        .reset      (reset),
        .barramento (bus)
    );

    always #5 clk = ~clk;

    function automatic amostra_t observa();
        return {bus.saida, bus.sel, bus.passo, bus.ocupado};
    endfunction

    function automatic logic [7:0] desloca(input logic [7:0] v, input logic dir, input logic rot);
        if (dir) return {v[6:0], rot ? v[7] : 1'b0};
        else     return {rot ? v[0] : 1'b0, v[7:1]};
    endfunction

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic borda();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        amostra_t e, o;
        reset = 1'b1;
        borda();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            fila.push_back({8'h00, 2'b11, 1'b0, 1'b0});
            borda();
            e = fila.pop_front();
            o = observa();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_idle ciclo %0d: obtido %b esperado %b", i, o, e);
            end
        end
    endtask

    // Load a pattern with scrolling enabled and follow n edges of it.
    task automatic test_rolagem(input string nome, input logic [7:0] padrao, input logic dir,
                                input logic rot, input int n, input logic [7:0] final_esperado);
        amostra_t e, o;
        logic [7:0] v;
        bus.entrada_paralela = padrao;
        bus.rolar    = 1'b1;
        bus.direcao  = dir;
        bus.rotacao  = rot;
        bus.carregar = 1'b1;
        fila.push_back({padrao, 2'b00, 1'b0, 1'b1});
        borda();
        bus.carregar = 1'b0;
        e = fila.pop_front();
        o = observa();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL %s carga: obtido %b esperado %b", nome, o, e);
        end
        v = padrao;
        for (int k = 1; k <= n; k++) begin
            if (k % DIV_PASSO == 0) begin
                v = desloca(v, dir, rot);
                fila.push_back({v, dir ? 2'b10 : 2'b01, 1'b1, 1'b1});
            end else begin
                fila.push_back({v, 2'b11, 1'b0, 1'b1});
            end
            borda();
            e = fila.pop_front();
            o = observa();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s borda %0d: obtido %b esperado %b", nome, k, o, e);
            end
        end
        checks++;
        if (bus.saida !== final_esperado) begin
            errors++;
            $display("FAIL %s final: saida=%b esperado %b", nome, bus.saida, final_esperado);
        end
    endtask

    task automatic test_carga_durante_rolagem();
        amostra_t e, o;
        bus.entrada_paralela = 8'b0011_1100;
        bus.rolar    = 1'b1;
        bus.direcao  = 1'b0;
        bus.rotacao  = 1'b1;
        bus.carregar = 1'b1;
        fila.push_back({8'b0011_1100, 2'b00, 1'b0, 1'b1});
        fila.push_back({8'b0011_1100, 2'b11, 1'b0, 1'b1});
        fila.push_back({8'b0011_1100, 2'b11, 1'b0, 1'b1});
        fila.push_back({8'b1111_0000, 2'b00, 1'b0, 1'b1});
        fila.push_back({8'b1111_0000, 2'b11, 1'b0, 1'b1});
        fila.push_back({8'b1111_0000, 2'b11, 1'b0, 1'b1});
        fila.push_back({8'b1111_0000, 2'b11, 1'b0, 1'b1});
        fila.push_back({8'b0111_1000, 2'b01, 1'b1, 1'b1});
        fila.push_back({8'b0111_1000, 2'b11, 1'b0, 1'b1});
        fila.push_back({8'b0111_1000, 2'b11, 1'b0, 1'b1});
        fila.push_back({8'b0111_1000, 2'b11, 1'b0, 1'b0});
        fila.push_back({8'b0111_1000, 2'b11, 1'b0, 1'b0});
        fila.push_back({8'b0111_1000, 2'b11, 1'b0, 1'b0});
        fila.push_back({8'b0111_1000, 2'b11, 1'b0, 1'b0});
        for (int k = 0; k < 14; k++) begin
            bus.carregar = (k == 0 || k == 3);
            bus.entrada_paralela = (k == 3) ? 8'b1111_0000 : 8'b0011_1100;
            bus.rolar = (k < 10);
            borda();
            e = fila.pop_front();
            o = observa();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL carga_durante borda %0d: obtido %b esperado %b", k, o, e);
            end
        end
        bus.carregar = 1'b0;
    endtask

    task automatic test_back_to_back();
        amostra_t e, o;
        logic [7:0] padroes [3] = '{8'hA5, 8'h5A, 8'hC3};
        bus.rolar = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.carregar = 1'b1;
            bus.entrada_paralela = padroes[k];
            fila.push_back({padroes[k], 2'b00, 1'b0, 1'b0});
            borda();
            e = fila.pop_front();
            o = observa();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL back_to_back carga %0d: obtido %b esperado %b", k, o, e);
            end
        end
        bus.carregar = 1'b0;
        fila.push_back({8'hC3, 2'b11, 1'b0, 1'b0});
        borda();
        e = fila.pop_front();
        o = observa();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL back_to_back ocioso: obtido %b esperado %b", o, e);
        end
    endtask

    task automatic test_reset_meio();
        amostra_t e, o;
        bus.entrada_paralela = 8'hFF;
        bus.rolar    = 1'b1;
        bus.carregar = 1'b1;
        borda();
        bus.carregar = 1'b0;
        borda();
        borda();
        reset = 1'b1;
        fila.push_back({8'h00, 2'b11, 1'b0, 1'b0});
        borda();
        reset = 1'b0;
        bus.rolar = 1'b0;
        e = fila.pop_front();
        o = observa();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL reset_meio: obtido %b esperado %b", o, e);
        end
`ifdef CONTADOR_PASSOS_EN
        checks++;
        if (bus.num_passos !== 3'd0 || bus.volta_completa !== 1'b0) begin
            errors++;
            $display("FAIL reset_meio contador: num=%0d volta=%b esperado 0 0",
                     bus.num_passos, bus.volta_completa);
        end
`endif
    endtask

`ifdef CONTADOR_PASSOS_EN
    task automatic test_contador();
        int n_esp;
        logic volta_esp;
        bus.entrada_paralela = 8'b1001_0110;
        bus.rolar    = 1'b1;
        bus.direcao  = 1'b0;
        bus.rotacao  = 1'b1;
        bus.carregar = 1'b1;
        borda();
        bus.carregar = 1'b0;
        n_esp = 0;
        for (int k = 1; k <= LARGURA * DIV_PASSO; k++) begin
            volta_esp = 1'b0;
            if (k % DIV_PASSO == 0) begin
                n_esp = (n_esp + 1) % LARGURA;
                volta_esp = (n_esp == 0);
            end
            borda();
            checks++;
            if (bus.num_passos !== 3'(n_esp) || bus.volta_completa !== volta_esp
                || bus.passo !== (k % DIV_PASSO == 0)) begin
                errors++;
                $display("FAIL contador borda %0d: num=%0d volta=%b passo=%b esperado num=%0d volta=%b",
                         k, bus.num_passos, bus.volta_completa, bus.passo, n_esp, volta_esp);
            end
        end
        checks++;
        if (bus.saida !== 8'b1001_0110) begin
            errors++;
            $display("FAIL contador volta_padrao: saida=%b esperado 10010110", bus.saida);
        end
        bus.rolar = 1'b0;
        borda();
    endtask
`endif

    initial begin
        reset = 1'b1;
        bus.carregar = 1'b0;
        bus.entrada_paralela = '0;
        bus.rolar   = 1'b0;
        bus.direcao = 1'b0;
        bus.rotacao = 1'b0;
        test_reset();
        test_rolagem("rot_msb", 8'b1000_0001, 1'b1, 1'b1, 8, 8'b0000_0110);
        test_rolagem("zero_lsb", 8'b0000_0001, 1'b0, 1'b0, 8, 8'b0000_0000);
        test_rolagem("rot_lsb", 8'b0000_0001, 1'b0, 1'b1, 8, 8'b0100_0000);
        test_carga_durante_rolagem();
        test_back_to_back();
`ifdef CONTADOR_PASSOS_EN
        test_contador();
`endif
        test_reset_meio();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/controle_rolagem.md
Name: controle_rolagem

Overview:
- Sequenced universal shift register for the electronic display panel.
- Issues the 2-bit cell command codes itself (parallel load, take-from-next, take-from-previous, hold) and applies them to a LARGURA-bit register.
- Scrolls a loaded pattern left or right at a programmable step rate, with rotate or zero-fill at the ends.
- Sits between the message source (parallel pattern) and the panel column drivers (saida).

Parameters:
- LARGURA, 8: register/panel width in bits, ≥2.
- DIV_PASSO, 4: clock cycles per scroll step, ≥1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- carregar  input  1  load request, sampled each edge.
- entrada_paralela  input  LARGURA  pattern captured on load.
- rolar  input  1  scroll enable; 0 = hold.
- direcao  input  1  0: bit i takes bit i+1 (toward LSB); 1: bit i takes bit i-1 (toward MSB).
- rotacao  input  1  1: end bit wraps around; 0: end bit fills with 0.
- sel  output  2  registered code of the operation applied at the last edge.
- saida  output  LARGURA  register contents.
- passo  output  1  one-cycle pulse after each shift.
- ocupado  output  1  high while in the CONTA state.

Behaviour:
- Reset (synchronous, active-high, overrides all inputs): saida=0, sel=11, passo=0, ocupado=0, step counter=0, state OCIOSO.
- Command codes:
  - 00 = load.
  - 01 = take next (bit i+1).
  - 10 = take previous (bit i-1).
  - 11 = hold.
- States: OCIOSO, CONTA.
- Load has priority over everything in any state:
  - Edge with carregar=1: saida<=entrada_paralela, sel<=00, counter<=0, passo<=0.
  - Next state is CONTA if rolar=1, else OCIOSO.
- OCIOSO:
  - saida holds, sel<=11, counter held at 0.
  - rolar=1 → CONTA.
- CONTA, counter < DIV_PASSO-1:
  - counter++, saida holds, sel<=11.
- CONTA, counter == DIV_PASSO-1 (edge):
  - Shift per direcao and rotacao; sel<=01 (direcao=0) or 10 (direcao=1); passo<=1; counter<=0.
  - direcao and rotacao are sampled at this edge only.
- Result: first shift lands on the DIV_PASSO-th edge after the load edge; then every DIV_PASSO edges.
- End bits:
  - direcao=0: MSB <= rotacao ? old bit0 : 0.
  - direcao=1: LSB <= rotacao ? old MSB : 0.
- rolar=0 while in CONTA: next edge → OCIOSO, counter<=0, no shift. The partial count is discarded.
- DIV_PASSO=1: shift on every edge while rolar=1.
- passo is high exactly one cycle per shift and never after a load.
- ocupado = (state==CONTA), registered.
- Direction changes take effect at the next shift edge, with no extra delay.

Optional Feature:
- Macro: CONTADOR_PASSOS_EN.
- When defined, two extra outputs are added:
  - num_passos, width $clog2(LARGURA): counts shifts modulo LARGURA; cleared by reset and by load.
  - volta_completa, 1 bit: one-cycle pulse, coincident with passo, when num_passos wraps from LARGURA-1 to 0.
- When undefined: neither port exists and no counter logic is present.

Decomposition:
- Package pkg_rolagem holds:
  - Code constants SEL_CARGA=2'b00, SEL_POSTERIOR=2'b01, SEL_ANTERIOR=2'b10, SEL_MANTEM=2'b11.
  - The state enum {OCIOSO, CONTA}.
- Sub-module celula_deslocamento: one bit cell with a flop and a 4:1 select on the 2-bit code. Inputs are entrada_paralela, next neighbour, previous neighbour and own output. It is instantiated LARGURA times via generate.
- End-cell neighbours come from rotate/zero-fill muxing in the top level.

Test Plan (LARGURA=8, DIV_PASSO=4):
- Reset then idle: saida=00000000, sel=11, passo=0, ocupado=0 for 10 cycles.
- Load 10000001, rolar=1, direcao=1, rotacao=1:
  - 4 edges after load: saida=00000011, sel=10, passo pulse.
  - 8 edges after load: saida=00000110.
- Load 00000001, direcao=0, rotacao=0: first shift gives 00000000; a second shift keeps 00000000.
- Load 00000001, direcao=0, rotacao=1: shifts give 10000000, then 01000000. sel=01 on each shift.
- Scroll running, carregar pulsed with 11110000 at count 2: saida=11110000 next edge, counter restarts, next shift 4 edges later. rolar dropped mid-count: saida holds, ocupado=0, no passo.
- With CONTADOR_PASSOS_EN, rotate 8 steps:
  - volta_completa pulses on the 8th passo and num_passos returns to 0.
  - The pattern equals the loaded value.
  - reset asserted mid-count clears all outputs on the next edge.
